// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that drive the shared memory and therefore wait on mem_ready.
  function automatic logic isMemState(input statetype s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

  function automatic logic isLegalOp(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/ctrl_wait_watchdog.sv
// Counts consecutive memory wait cycles and raises a sticky timeout flag.
// TIMEOUT_CYCLES = 0 disables the flag entirely.
module ctrl_wait_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  output logic o_timeout
);

  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
  localparam int CW = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic          r_timeout;

  // Saturates at LIMIT so a stuck memory never wraps the count back to zero.
  always_comb begin
    w_countNext = '0;
    if (i_wait) begin
      w_countNext = (r_count == LIMIT) ? r_count : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_count   <= w_countNext;
      r_timeout <= r_timeout | (ENABLED && (w_countNext == LIMIT));
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RISC-V core with memory handshake and wait watchdog.
// Define ILLEGAL_OP_TRAP_EN to trap unsupported opcodes instead of treating them as NOPs.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       mem_timeout
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  statetype r_state;
  logic     w_memWait;
  logic     w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:    if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_R:         r_state <= EXECUTER;
            OP_I:         r_state <= EXECUTEI;
            OP_BEQ:       r_state <= BEQ;
            OP_JAL:       r_state <= JAL;
`ifdef ILLEGAL_OP_TRAP_EN
            default:      r_state <= TRAP;
`else
            default:      r_state <= FETCH;
`endif
          endcase
        end
        MEMADR:   r_state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        MEMWRITE: if (mem_ready) r_state <= FETCH;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        ALUWB:    r_state <= FETCH;
        BEQ:      r_state <= FETCH;
        JAL:      r_state <= ALUWB;
        TRAP:     r_state <= TRAP;
        default:  r_state <= FETCH;
      endcase
    end
  end

  // Outputs are decoded from state, with memory enables gated by mem_ready in the
  // same cycle; reset forces everything low so an abandoned instruction writes nothing.
  always_comb begin
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUOp      = ALUOP_ADD;
    instr_done = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = mem_ready;
          PCUpdate  = mem_ready;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
`ifndef ILLEGAL_OP_TRAP_EN
          instr_done = !isLegalOp(op);
`endif
        end
        MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        MEMREAD: AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc  = RES_DATA;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        EXECUTER: begin
          ALUSrcA = SRCA_RD1;
          ALUOp   = ALUOP_FUNCT;
        end
        EXECUTEI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BEQ: begin
          ALUSrcA    = SRCA_RD1;
          ALUOp      = ALUOP_SUB;
          Branch     = 1'b1;
          instr_done = 1'b1;
        end
        JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCUpdate = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_memWait = isMemState(r_state) && !mem_ready;

  ctrl_wait_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_wait   (w_memWait),
    .o_timeout(w_timeout)
  );

  assign mem_timeout = w_timeout & ~reset;

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = (r_state == TRAP) & ~reset;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-instruction step model plus watchdog model.
// Honours ILLEGAL_OP_TRAP_EN the same way the design does.
module tb_multicycle_ctrl_fsm;

  localparam int TIMEOUT = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Instruction phases as the bench sees them, independent of the design's encoding.
  localparam int S_FETCH = 0, S_DEC = 1, S_MADR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5;
  localparam int S_EXR = 6, S_EXI = 7, S_AWB = 8, S_BEQ = 9, S_JAL = 10, S_TRAP = 11, S_DECNOP = 12;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic       memReady = 1'b0;
  logic       pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
  logic       instrDone, memTimeout;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegalOp;
`endif

  int          checks = 0;
  int          errors = 0;
  bit          checkEn = 1'b0;
  logic [14:0] expWord = '0;
  logic        expTimeout = 1'b0;
  logic        expIllegal = 1'b0;
  int          waitRun = 0;
  bit          tFlag = 1'b0;
  int          curStep = 0;

  multicycle_ctrl_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (memReady),
    .PCUpdate   (pcUpdate),
    .Branch     (branch),
    .RegWrite   (regWrite),
    .MemWrite   (memWrite),
    .IRWrite    (irWrite),
    .AdrSrc     (adrSrc),
    .ResultSrc  (resultSrc),
    .ALUSrcA    (aluSrcA),
    .ALUSrcB    (aluSrcB),
    .ALUOp      (aluOp),
    .instr_done (instrDone),
    .mem_timeout(memTimeout)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .illegal_op (illegalOp)
`endif
  );

  always #5 clk = ~clk;

  // Required control word for one phase: {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,
  // AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,instr_done}.
  function automatic logic [14:0] expWordFor(input int s, input logic rdy);
    logic pcU, br, rw, mw, ir, adr, done;
    logic [1:0] res, sa, sb, aop;
    {pcU, br, rw, mw, ir, adr, done} = '0;
    {res, sa, sb, aop} = '0;
    case (s)
      S_FETCH:  begin sb = 2'b10; res = 2'b10; ir = rdy; pcU = rdy; end
      S_DEC:    begin sa = 2'b01; sb = 2'b01; end
      S_DECNOP: begin sa = 2'b01; sb = 2'b01; done = 1'b1; end
      S_MADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MRD:    adr = 1'b1;
      S_MWB:    begin res = 2'b01; rw = 1'b1; done = 1'b1; end
      S_MWR:    begin adr = 1'b1; mw = 1'b1; done = rdy; end
      S_EXR:    begin sa = 2'b10; aop = 2'b10; end
      S_EXI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      S_AWB:    begin rw = 1'b1; done = 1'b1; end
      S_BEQ:    begin sa = 2'b10; aop = 2'b01; br = 1'b1; done = 1'b1; end
      S_JAL:    begin sa = 2'b01; sb = 2'b10; pcU = 1'b1; end
      default:  ;
    endcase
    return {pcU, br, rw, mw, ir, adr, res, sa, sb, aop, done};
  endfunction

  function automatic bit isLegal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
  endfunction

  // Compare process: checks every cycle against the model, away from the clock edge.
  always begin
    @(negedge clk);
    #2;
    if (checkEn) begin
      checks++;
      if ({pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
           resultSrc, aluSrcA, aluSrcB, aluOp, instrDone} !== expWord) begin
        errors++;
        $display("[TB] FAIL ctrlWord step=%0d actual=%h required=%h", curStep,
                 {pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
                  resultSrc, aluSrcA, aluSrcB, aluOp, instrDone}, expWord);
      end
      checks++;
      if (memTimeout !== expTimeout) begin
        errors++;
        $display("[TB] FAIL memTimeout step=%0d actual=%b required=%b", curStep, memTimeout, expTimeout);
      end
`ifdef ILLEGAL_OP_TRAP_EN
      checks++;
      if (illegalOp !== expIllegal) begin
        errors++;
        $display("[TB] FAIL illegalOp step=%0d actual=%b required=%b", curStep, illegalOp, expIllegal);
      end
`endif
    end
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset      = 1'b1;
      memReady   = 1'($urandom_range(0, 1));
      op         = 7'($urandom);
      curStep    = -1;
      expWord    = '0;
      expTimeout = 1'b0;
      expIllegal = 1'b0;
      waitRun    = 0;
      tFlag      = 1'b0;
      checkEn    = 1'b1;
    end
  endtask

  // Runs one instruction: fW wait cycles in fetch, mW in the data memory phase.
  // abortAfter > 0 stops after that many cycles; doneCycle is when the DUT pulsed instr_done.
  task automatic applyStimulus(input logic [6:0] opc, input int fW, input int mW,
                               input int abortAfter, output int doneCycle);
    int steps[$];
    int cyc;
    int s;
    int waitLeft;
    bit isWait;
    bit adv;
    cyc = 0;
    doneCycle = 0;
    case (opc)
      LW: steps = '{S_FETCH, S_DEC, S_MADR, S_MRD, S_MWB};
      SW: steps = '{S_FETCH, S_DEC, S_MADR, S_MWR};
      RT: steps = '{S_FETCH, S_DEC, S_EXR, S_AWB};
      IT: steps = '{S_FETCH, S_DEC, S_EXI, S_AWB};
      BQ: steps = '{S_FETCH, S_DEC, S_BEQ};
      JL: steps = '{S_FETCH, S_DEC, S_JAL, S_AWB};
      default:
        if (TRAP_BUILD) steps = '{S_FETCH, S_DEC, S_TRAP, S_TRAP, S_TRAP, S_TRAP};
        else            steps = '{S_FETCH, S_DECNOP};
    endcase
    for (int k = 0; k < steps.size(); k++) begin
      s        = steps[k];
      isWait   = (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
      waitLeft = (s == S_FETCH) ? fW : (isWait ? mW : 0);
      adv      = 1'b0;
      while (!adv) begin
        if (abortAfter > 0 && cyc == abortAfter) return;
        @(negedge clk);
        reset      = 1'b0;
        op         = opc;
        memReady   = isWait ? (waitLeft == 0) : 1'($urandom_range(0, 1));
        adv        = !isWait || memReady;
        curStep    = s;
        expWord    = expWordFor(s, memReady);
        expTimeout = tFlag;
        expIllegal = (s == S_TRAP);
        if (isWait && !memReady) waitRun++;
        else                     waitRun = 0;
        if (waitRun >= TIMEOUT) tFlag = 1'b1;
        checkEn = 1'b1;
        cyc++;
        #2;
        if (instrDone === 1'b1 && doneCycle == 0) doneCycle = cyc;
        if (waitLeft > 0) waitLeft--;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeLimit actual=expired required=finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int dc;
    logic [6:0] opTable[8];
    logic [6:0] opc;
    int fW, mW;

    applyReset(2);

    applyStimulus(LW, 0, 0, 0, dc);  checkOutput("latencyLw", dc, 5);
    applyStimulus(SW, 0, 0, 0, dc);  checkOutput("latencySw", dc, 4);
    applyStimulus(RT, 0, 0, 0, dc);  checkOutput("latencyR", dc, 4);
    applyStimulus(IT, 0, 0, 0, dc);  checkOutput("latencyI", dc, 4);
    applyStimulus(BQ, 0, 0, 0, dc);  checkOutput("latencyBeq", dc, 3);
    applyStimulus(JL, 0, 0, 0, dc);  checkOutput("latencyJal", dc, 4);
    applyStimulus(SW, 0, 3, 0, dc);  checkOutput("latencySwWait3", dc, 7);
    applyStimulus(LW, 2, 1, 0, dc);  checkOutput("latencyLwWaits", dc, 8);

    applyStimulus(BAD, 0, 0, 0, dc);
    if (TRAP_BUILD) begin
      checkOutput("trapNoDone", dc, 0);
      applyReset(1);
    end else begin
      checkOutput("nopDone", dc, 2);
    end

    applyStimulus(RT, 3, 0, 0, dc);
    checkOutput("timeoutAfter3", int'(memTimeout), 0);
    applyStimulus(RT, 6, 0, 0, dc);
    checkOutput("timeoutAfter6", int'(memTimeout), 1);
    applyStimulus(BQ, 0, 0, 0, dc);
    checkOutput("timeoutSticky", int'(memTimeout), 1);
    applyReset(1);

    applyStimulus(SW, 0, 5, 5, dc);
    checkOutput("memWriteBeforeReset", int'(memWrite), 1);
    applyReset(2);
    applyStimulus(BQ, 0, 0, 0, dc);
    checkOutput("latencyAfterReset", dc, 3);

    opTable = '{LW, SW, RT, IT, BQ, JL, BAD, 7'b0};
    for (int n = 0; n < 300; n++) begin
      opTable[7] = 7'($urandom);
      opc = opTable[$urandom_range(0, 7)];
      fW  = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
      mW  = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
      applyStimulus(opc, fW, mW, 0, dc);
      if (TRAP_BUILD && !isLegal(opc)) applyReset(1);
      else if ($urandom_range(0, 24) == 0) applyReset(1);
    end

    @(negedge clk);
    checkEn = 1'b0;
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the multicycle RISC-V core. It sequences one shared ALU, one unified instruction/data memory and the register file across several cycles per instruction (lw, sw, R-type, I-type ALU, beq, jal). It replaces the single-cycle main decoder in the multicycle datapath and adds a memory ready handshake plus a wait-state watchdog. Funct-field ALU decoding (aludec) and ImmSrc generation remain separate combinational blocks fed by this FSM.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive mem_ready-low cycles in a memory state before mem_timeout is raised; 0 disables the watchdog.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  7  opcode field of the instruction register (instr[6:0])
mem_ready  input  1  memory completes the current access this cycle
PCUpdate  output  1  write PC unconditionally
Branch  output  1  PC write qualified by Zero (beq)
RegWrite  output  1  register file write enable
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register / OldPC load
AdrSrc  output  1  memory address select: 0=PC, 1=Result
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
mem_timeout  output  1  sticky flag: watchdog expired

Behaviour:
- Registered state; Moore outputs decoded from state; memory-state enables additionally qualified by mem_ready.
- Reset (synchronous, active-high): next state FETCH. All outputs are 0 while reset is high. mem_timeout and the watchdog counter clear. Reset mid-instruction abandons the instruction; no write enable is asserted in that cycle.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> see Optional Feature.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. When mem_ready: instr_done=1 and next FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB.
- Unlisted outputs are 0 in every state.
- Latencies with zero wait states: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4. Each memory wait cycle adds one cycle.
- Watchdog:
  - Counter increments on every cycle in FETCH, MEMREAD or MEMWRITE with !mem_ready; clears on mem_ready or on leaving those states.
  - When the count reaches TIMEOUT_CYCLES, mem_timeout sets and stays set until reset. The FSM keeps waiting; it does not abort.
  - The counter saturates and never wraps.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: an unsupported op in DECODE goes to state TRAP. TRAP holds all outputs 0 until reset, and the output illegal_op (1 bit, present only when defined) is 1 in TRAP.
- Undefined: an unsupported op in DECODE goes to FETCH (executed as a NOP) with instr_done=1 in DECODE; no illegal_op port.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - statetype enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP)
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - encoding constants for ResultSrc, ALUSrcA, ALUSrcB and ALUOp
- One natural sub-module: ctrl_wait_watchdog (saturating counter plus sticky flag).

Test Plan:
- Reset held 2 cycles during MEMWRITE with MemWrite=1 -> MemWrite=0 in the reset cycles; state FETCH on the first cycle after release.
- op=0000011, mem_ready always 1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; instr_done pulses in cycle 5.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; instr_done on the 4th; next state FETCH.
- op=1100011 -> 3 cycles; Branch=1 and ALUOp=01 only in BEQ. op=1101111 -> JAL state has PCUpdate=1, then ALUWB has RegWrite=1 with ResultSrc=00.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready returns; IRWrite=0 throughout the wait.
- op=1111111 -> with the macro: TRAP and illegal_op=1 until reset; without it: back to FETCH after DECODE with no write enable asserted.
